// File: rtl/mem_stage.sv
// mem_stage: holds one instruction between EX and WB. It waits for the load response, extracts the load data, and feeds the bypass to ID.
// Latency: a non-load retires the cycle after it is accepted. A load retires in the same cycle as dmem_rvalid (the data path is combinational from rdata).
// Backpressure: i_ex_ready drops while a load waits without rvalid, and while a flushed load's response is drained.
//
// Ports:
//   i_clk, i_rst               clock; synchronous active-high reset
//   i_flush                    discard the held instruction, accept nothing this cycle
//   i_ex_*, o_ex_ready         instruction hand-off from EX (valid/ready)
//   i_dmem_rvalid/rdata        data SRAM load response
//   o_wb_*                     retiring instruction toward WB
//   o_fwd_*                    bypass to ID; o_fwd_pending flags a load-use stall
// Optional feature: define MEM_SUBWORD_EN for byte/half extraction and sign/zero extension.
// Without it, every load returns dmem_rdata unchanged.
module mem_stage #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RA_W   = 5
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_flush,
   input  logic                          i_ex_valid,
   output logic                          o_ex_ready,
   input  logic [PC_W-1:0]               i_ex_pc,
   input  logic                          i_ex_load,
   input  logic [1:0]                    i_ex_size,
   input  logic                          i_ex_signed,
   input  logic [$clog2(DATA_W/8)-1:0]   i_ex_addr_lo,
   input  logic                          i_ex_rf_we,
   input  logic [RA_W-1:0]               i_ex_rf_waddr,
   input  logic [DATA_W-1:0]             i_ex_result,
   input  logic                          i_dmem_rvalid,
   input  logic [DATA_W-1:0]             i_dmem_rdata,
   output logic                          o_wb_valid,
   output logic [PC_W-1:0]               o_wb_pc,
   output logic                          o_wb_rf_we,
   output logic [RA_W-1:0]               o_wb_rf_waddr,
   output logic [DATA_W-1:0]             o_wb_rf_wdata,
   output logic                          o_fwd_we,
   output logic [RA_W-1:0]               o_fwd_waddr,
   output logic [DATA_W-1:0]             o_fwd_wdata,
   output logic                          o_fwd_pending
);

   localparam int AW = $clog2(DATA_W/8);

   typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_WAIT, S_DRAIN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PC_W-1:0]     r_pc;
   logic                r_rf_we;
   logic [RA_W-1:0]     r_rf_waddr;
   logic [DATA_W-1:0]   r_result;
   logic                w_ready;
   logic                w_accept;
   logic                w_wb_valid;
   logic [DATA_W-1:0]   w_load_data;
   logic [DATA_W-1:0]   w_wdata;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_ready     = (r_state == S_EMPTY) || (r_state == S_HOLD) ||
                    ((r_state == S_WAIT) && i_dmem_rvalid);
      // Flush blocks acceptance even though ready itself does not depend on it.
      w_accept    = i_ex_valid && w_ready && !i_flush;
      w_wb_valid  = !i_flush && ((r_state == S_HOLD) ||
                                 ((r_state == S_WAIT) && i_dmem_rvalid));
      w_state_nxt = r_state;
      if (i_flush) begin
         // A load still waiting leaves a response in flight, so it must be drained.
         w_state_nxt = ((r_state == S_WAIT) && !i_dmem_rvalid) ? S_DRAIN : S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY, S_HOLD, S_WAIT: begin
               if (r_state != S_WAIT || i_dmem_rvalid) begin
                  if (w_accept) begin
                     w_state_nxt = i_ex_load ? S_WAIT : S_HOLD;
                  end else begin
                     w_state_nxt = S_EMPTY;
                  end
               end
            end
            S_DRAIN: begin
               if (i_dmem_rvalid) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc       <= '0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_result   <= '0;
      end else if (w_accept) begin
         r_pc       <= i_ex_pc;
         r_rf_we    <= i_ex_rf_we;
         r_rf_waddr <= i_ex_rf_waddr;
         r_result   <= i_ex_result;
      end
   end

`ifdef MEM_SUBWORD_EN
   logic [1:0]          r_size;
   logic                r_signed;
   logic [AW-1:0]       r_addr_lo;
   logic [AW-1:0]       w_half_lo;
   logic [DATA_W-1:0]   w_byte_sh;
   logic [DATA_W-1:0]   w_half_sh;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_size    <= 2'd0;
         r_signed  <= 1'b0;
         r_addr_lo <= '0;
      end else if (w_accept) begin
         r_size    <= i_ex_size;
         r_signed  <= i_ex_signed;
         r_addr_lo <= i_ex_addr_lo;
      end
   end

   always_comb begin
      // The halfword lane ignores address bit 0.
      w_half_lo = r_addr_lo & ~AW'(1);
      w_byte_sh = i_dmem_rdata >> {r_addr_lo, 3'b000};
      w_half_sh = i_dmem_rdata >> {w_half_lo, 3'b000};
      case (r_size)
         2'd0:    w_load_data = {{(DATA_W-8){r_signed & w_byte_sh[7]}}, w_byte_sh[7:0]};
         2'd1:    w_load_data = {{(DATA_W-16){r_signed & w_half_sh[15]}}, w_half_sh[15:0]};
         default: w_load_data = i_dmem_rdata;
      endcase
   end
`else
   logic w_unused_subword;
   assign w_unused_subword = ^{i_ex_size, i_ex_signed, i_ex_addr_lo};
   assign w_load_data      = i_dmem_rdata;
`endif

   assign w_wdata       = (r_state == S_WAIT) ? w_load_data : r_result;

   assign o_ex_ready    = w_ready;
   assign o_wb_valid    = w_wb_valid;
   assign o_wb_pc       = r_pc;
   assign o_wb_rf_we    = r_rf_we & w_wb_valid;
   assign o_wb_rf_waddr = r_rf_waddr;
   assign o_wb_rf_wdata = w_wdata;
   assign o_fwd_we      = r_rf_we & w_wb_valid;
   assign o_fwd_waddr   = r_rf_waddr;
   assign o_fwd_wdata   = w_wdata;
   assign o_fwd_pending = (r_state == S_WAIT) && r_rf_we && !i_dmem_rvalid;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: a directed per-cycle vector table, a reset-in-WAIT sequence,
// and a randomized run checked against an instruction-level reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst, flush, ex_valid, ex_ready, ex_load, ex_signed, ex_rf_we;
   logic [31:0] ex_pc, ex_result, dmem_rdata, wb_pc, wb_rf_wdata, fwd_wdata;
   logic [1:0]  ex_size, ex_addr_lo;
   logic [4:0]  ex_rf_waddr, wb_rf_waddr, fwd_waddr;
   logic        dmem_rvalid, wb_valid, wb_rf_we, fwd_we, fwd_pending;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_ex_valid(ex_valid),
      .o_ex_ready(ex_ready), .i_ex_pc(ex_pc), .i_ex_load(ex_load),
      .i_ex_size(ex_size), .i_ex_signed(ex_signed), .i_ex_addr_lo(ex_addr_lo),
      .i_ex_rf_we(ex_rf_we), .i_ex_rf_waddr(ex_rf_waddr), .i_ex_result(ex_result),
      .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
      .o_wb_valid(wb_valid), .o_wb_pc(wb_pc), .o_wb_rf_we(wb_rf_we),
      .o_wb_rf_waddr(wb_rf_waddr), .o_wb_rf_wdata(wb_rf_wdata),
      .o_fwd_we(fwd_we), .o_fwd_waddr(fwd_waddr), .o_fwd_wdata(fwd_wdata),
      .o_fwd_pending(fwd_pending)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference load extraction computed with plain arithmetic.
   function automatic logic [31:0] ref_ext(input int sz, input bit sg, input int a,
                                           input logic [31:0] rd);
      logic [31:0] v;
      v = rd;
`ifdef MEM_SUBWORD_EN
      if (sz == 0) begin
         v = (rd >> (8 * a)) & 32'hFF;
         if (sg && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (sz == 1) begin
         v = (rd >> (16 * (a / 2))) & 32'hFFFF;
         if (sg && v >= 32'd32768) v = v | 32'hFFFF0000;
      end
`endif
      return v;
   endfunction

   typedef struct {
      logic fl, v, ld; logic [1:0] sz; logic sg; logic [1:0] a; logic [4:0] wa;
      logic [31:0] res; logic rv; logic [31:0] rd;
      logic e_rdy, e_v, e_pend; logic [31:0] e_wd;
   } vec_t;

   function automatic vec_t mk(input logic fl, v, ld, input logic [1:0] sz, input logic sg,
                               input logic [1:0] a, input logic [4:0] wa, input logic [31:0] res,
                               input logic rv, input logic [31:0] rd,
                               input logic e_rdy, e_v, e_pend, input logic [31:0] e_wd);
      vec_t t;
      t.fl = fl; t.v = v; t.ld = ld; t.sz = sz; t.sg = sg; t.a = a; t.wa = wa;
      t.res = res; t.rv = rv; t.rd = rd;
      t.e_rdy = e_rdy; t.e_v = e_v; t.e_pend = e_pend; t.e_wd = e_wd;
      return t;
   endfunction

`ifdef MEM_SUBWORD_EN
   localparam logic [31:0] EXP_SB = 32'hFFFFFFA5;
   localparam logic [31:0] EXP_UH = 32'h00008001;
`else
   localparam logic [31:0] EXP_SB = 32'h00A50000;
   localparam logic [31:0] EXP_UH = 32'h80010000;
`endif

   // Reference model: the held instruction, plus a flag for a drained response.
   bit          m_have, m_ld, m_drain, m_we, m_sg;
   logic [4:0]  m_wa;
   logic [31:0] m_pc, m_res;
   int          m_sz, m_a;

   task automatic idle_inputs();
      rst = 0; flush = 0; ex_valid = 0; ex_load = 0; ex_size = 0; ex_signed = 0;
      ex_addr_lo = 0; ex_rf_we = 0; ex_rf_waddr = 0; ex_result = 0; ex_pc = 0;
      dmem_rvalid = 0; dmem_rdata = 0;
   endtask

   task automatic chk_all_reset();
      chk("rst ex_ready", 32'(ex_ready), 32'd1);
      chk("rst wb_valid", 32'(wb_valid), 32'd0);
      chk("rst wb_pc", wb_pc, 32'd0);
      chk("rst wb_rf_we", 32'(wb_rf_we), 32'd0);
      chk("rst wb_rf_waddr", 32'(wb_rf_waddr), 32'd0);
      chk("rst wb_rf_wdata", wb_rf_wdata, 32'd0);
      chk("rst fwd_we", 32'(fwd_we), 32'd0);
      chk("rst fwd_waddr", 32'(fwd_waddr), 32'd0);
      chk("rst fwd_wdata", fwd_wdata, 32'd0);
      chk("rst fwd_pending", 32'(fwd_pending), 32'd0);
   endtask

   vec_t tbl[22];

   initial begin
      logic e_rdy, e_v, e_pend;
      logic [31:0] e_wd;
      //             fl v ld sz sg a  wa   res           rv rd              rdy v pend wd
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             1, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 0, 0, 0, 3,  32'h12345678, 0, 0,             1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             1, 1, 0, 32'h12345678);
      tbl[3]  = mk(0, 1, 1, 0, 1, 2, 5,  32'h1000,     0, 0,             1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             0, 0, 1, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             0, 0, 1, 0);
      tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            1, 32'h00A50000,  1, 1, 0, EXP_SB);
      tbl[7]  = mk(0, 1, 1, 1, 0, 2, 6,  32'h2000,     0, 0,             1, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0,            1, 32'h80010000,  1, 1, 0, EXP_UH);
      tbl[9]  = mk(0, 1, 1, 2, 0, 0, 7,  0,            0, 0,             1, 0, 0, 0);
      tbl[10] = mk(0, 1, 1, 2, 0, 0, 8,  0,            1, 32'h11111111,  1, 1, 0, 32'h11111111);
      tbl[11] = mk(0, 1, 1, 2, 0, 0, 9,  0,            1, 32'h22222222,  1, 1, 0, 32'h22222222);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,  0,            1, 32'h33333333,  1, 1, 0, 32'h33333333);
      tbl[13] = mk(0, 1, 1, 2, 0, 0, 10, 0,            0, 0,             1, 0, 0, 0);
      tbl[14] = mk(1, 0, 0, 0, 0, 0, 0,  0,            0, 0,             0, 0, 1, 0);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             0, 0, 0, 0);
      tbl[16] = mk(0, 1, 0, 0, 0, 0, 12, 32'h5555,     1, 32'h0000DEAD,  0, 0, 0, 0);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             1, 0, 0, 0);
      tbl[18] = mk(1, 1, 0, 0, 0, 0, 13, 32'h6666,     0, 0,             1, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             1, 0, 0, 0);
      tbl[20] = mk(0, 1, 1, 2, 0, 0, 11, 0,            0, 0,             1, 0, 0, 0);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,  0,            0, 0,             0, 0, 1, 0);

      idle_inputs();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk_all_reset();

      // Directed per-cycle vectors; every instruction writes the register file.
      for (int i = 0; i < 22; i++) begin
         @(posedge clk); #1;
         flush = tbl[i].fl; ex_valid = tbl[i].v; ex_load = tbl[i].ld;
         ex_size = tbl[i].sz; ex_signed = tbl[i].sg; ex_addr_lo = tbl[i].a;
         ex_rf_we = 1; ex_rf_waddr = tbl[i].wa; ex_result = tbl[i].res;
         ex_pc = 32'h100 + 32'(i); dmem_rvalid = tbl[i].rv; dmem_rdata = tbl[i].rd;
         @(negedge clk);
         chk($sformatf("vec%0d ex_ready", i), 32'(ex_ready), 32'(tbl[i].e_rdy));
         chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_v));
         chk($sformatf("vec%0d wb_rf_we", i), 32'(wb_rf_we), 32'(tbl[i].e_v));
         chk($sformatf("vec%0d fwd_pending", i), 32'(fwd_pending), 32'(tbl[i].e_pend));
         if (tbl[i].e_v) begin
            chk($sformatf("vec%0d wb_rf_wdata", i), wb_rf_wdata, tbl[i].e_wd);
            chk($sformatf("vec%0d fwd_wdata", i), fwd_wdata, tbl[i].e_wd);
         end
      end

      // The stage is in WAIT here; reset must return it to an all-zero, ready state.
      @(posedge clk); #1;
      idle_inputs();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk_all_reset();

      // Randomized run against the reference model.
      m_have = 0; m_ld = 0; m_drain = 0; m_we = 0; m_sg = 0;
      m_wa = 0; m_pc = 0; m_res = 0; m_sz = 0; m_a = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 9) == 0);
         ex_valid = 1'($urandom_range(0, 1));
         ex_load = 1'($urandom_range(0, 1));
         ex_size = 2'($urandom_range(0, 2));
         ex_signed = 1'($urandom_range(0, 1));
         ex_addr_lo = 2'($urandom_range(0, 3));
         ex_rf_we = ($urandom_range(0, 3) != 0);
         ex_rf_waddr = 5'($urandom_range(0, 31));
         ex_pc = $urandom;
         ex_result = $urandom;
         dmem_rvalid = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
         @(negedge clk);
         e_rdy  = !m_drain && !(m_have && m_ld && !dmem_rvalid);
         e_v    = !flush && m_have && (!m_ld || dmem_rvalid);
         e_pend = m_have && m_ld && m_we && !dmem_rvalid;
         e_wd   = m_ld ? ref_ext(m_sz, m_sg, m_a, dmem_rdata) : m_res;
         chk("rnd ex_ready", 32'(ex_ready), 32'(e_rdy));
         chk("rnd wb_valid", 32'(wb_valid), 32'(e_v));
         chk("rnd wb_rf_we", 32'(wb_rf_we), 32'(e_v && m_we));
         chk("rnd fwd_we", 32'(fwd_we), 32'(e_v && m_we));
         chk("rnd fwd_pending", 32'(fwd_pending), 32'(e_pend));
         if (e_v) begin
            chk("rnd wb_rf_wdata", wb_rf_wdata, e_wd);
            chk("rnd wb_rf_waddr", 32'(wb_rf_waddr), 32'(m_wa));
            chk("rnd wb_pc", wb_pc, m_pc);
            chk("rnd fwd_wdata", fwd_wdata, e_wd);
            chk("rnd fwd_waddr", 32'(fwd_waddr), 32'(m_wa));
         end
         // Advance the model by one clock edge.
         if (rst) begin
            m_have = 0; m_drain = 0;
         end else if (flush) begin
            m_drain = m_have && m_ld && !dmem_rvalid;
            m_have = 0;
         end else if (m_drain) begin
            if (dmem_rvalid) m_drain = 0;
         end else if (!(m_have && m_ld && !dmem_rvalid)) begin
            m_have = 0;
            if (ex_valid && e_rdy) begin
               m_have = 1; m_ld = ex_load; m_we = ex_rf_we; m_wa = ex_rf_waddr;
               m_pc = ex_pc; m_res = ex_result; m_sz = int'(ex_size);
               m_sg = ex_signed; m_a = int'(ex_addr_lo);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
